// File: rtl/delay_capture_pkg.sv
// Shared types and helpers for the delay_capture snapshot buffer.
package delay_capture_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  // Width of the free-running cycle counter and the trigger timestamp
  localparam int STAMP_WIDTH = 32;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/delay_capture_ram.sv
// Simple dual-port capture RAM: synchronous write, registered read-first output.
// The storage array has no reset so it maps onto block RAM; only the output
// register is cleared by reset.
module delay_capture_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port: one sample per cycle when enabled
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port: registered, holds when idle; a same-address write returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/delay_capture.sv
// Snapshot capture buffer for the delay stage output stream.
// After an arm pulse, the first cycle with trig && din_valid && en stores DEPTH
// consecutive valid samples, which then stay available for host readout.
// Optional macro DELAY_CAPTURE_TIMESTAMP_EN adds a free-running cycle counter
// and the trig_stamp output latching it on the first write of each capture.
module delay_capture
  import delay_capture_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  localparam int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count
`ifdef DELAY_CAPTURE_TIMESTAMP_EN
  ,
  output logic [STAMP_WIDTH-1:0] trig_stamp
`endif
);

  cap_state_t            r_state;
  cap_state_t            w_state_next;
  logic                  w_wr_en;
  logic                  w_clear;
  logic                  w_first_wr;
  logic                  w_last_addr;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_rd_valid;

  assign w_last_addr = (r_wr_ptr == ADDR_WIDTH'(DEPTH - 1));
  assign w_first_wr  = w_wr_en && (r_state == ARMED);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state, write strobe and clear decode; arm in ARMED takes priority
  // over a trigger so a re-arm always restarts cleanly
  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_state_next = ARMED;
          w_clear      = 1'b1;
        end
      end
      ARMED: begin
        if (arm) begin
          w_clear = 1'b1;
        end else if (trig && din_valid && en) begin
          w_wr_en      = 1'b1;
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (din_valid && en) begin
          w_wr_en = 1'b1;
          if (w_last_addr) w_state_next = DONE;
        end
      end
      DONE: begin
        if (arm) begin
          w_state_next = ARMED;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Write pointer and sample count; writes stop at DEPTH so count saturates there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      r_count  <= r_count + (ADDR_WIDTH + 1)'(1);
    end
  end

  // Registered status decodes taken from the next state so they track r_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ARMED) || (w_state_next == CAPTURE);
      r_done <= (w_state_next == DONE);
    end
  end

  // Read valid follows the read request by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_valid <= 1'b0;
    else        r_rd_valid <= rd_en;
  end

  delay_capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (din),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

`ifdef DELAY_CAPTURE_TIMESTAMP_EN
  logic [STAMP_WIDTH-1:0] r_cycle_cnt;
  logic [STAMP_WIDTH-1:0] r_trig_stamp;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cycle_cnt <= '0;
    else        r_cycle_cnt <= r_cycle_cnt + STAMP_WIDTH'(1);
  end

  // Latch the cycle count in the cycle the address-0 sample is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_trig_stamp <= '0;
    else if (w_first_wr) r_trig_stamp <= r_cycle_cnt;
  end

  assign trig_stamp = r_trig_stamp;
`else
  logic w_unused_first_wr;
  assign w_unused_first_wr = w_first_wr;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign rd_valid = r_rd_valid;

endmodule
